score_display: RTL and testbench

Downstream consumer of the memory game's 8-bit score. It converts the binary score to three BCD digits with a sequential shift-add-3 converter, then time-multiplexes those digits onto the 3-anode seven-segment display. It replaces the free-running combinational conversion path with a registered, handshake-loaded one, so the displayed value changes atomically and only after a completed conversion.

---
 rtl/score_display_pkg.sv | 46 ++++
 rtl/bin2bcd_seq.sv | 86 ++++++++
 rtl/score_display.sv | 83 ++++++++
 tb/tb_score_display.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/score_display_pkg.sv
// Shared types and constants for the score display path: converter FSM states
// and active-low seven-segment / anode codes.
package score_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } conv_state_t;

  // Segment patterns are {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG7_0   = 7'b1000000;
  localparam logic [6:0] SEG7_1   = 7'b1111001;
  localparam logic [6:0] SEG7_2   = 7'b0100100;
  localparam logic [6:0] SEG7_3   = 7'b0110000;
  localparam logic [6:0] SEG7_4   = 7'b0011001;
  localparam logic [6:0] SEG7_5   = 7'b0010010;
  localparam logic [6:0] SEG7_6   = 7'b0000010;
  localparam logic [6:0] SEG7_7   = 7'b1111000;
  localparam logic [6:0] SEG7_8   = 7'b0000000;
  localparam logic [6:0] SEG7_9   = 7'b0010000;
  localparam logic [6:0] SEG7_OFF = 7'b1111111;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [2:0] AN_OFF    = 3'b111;

  function automatic logic [6:0] seg7_encode(input logic [3:0] d);
    logic [6:0] s;
    s = SEG7_OFF;
    case (d)
      4'd0: s = SEG7_0;
      4'd1: s = SEG7_1;
      4'd2: s = SEG7_2;
      4'd3: s = SEG7_3;
      4'd4: s = SEG7_4;
      4'd5: s = SEG7_5;
      4'd6: s = SEG7_6;
      4'd7: s = SEG7_7;
      4'd8: s = SEG7_8;
      4'd9: s = SEG7_9;
      default: s = SEG7_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-add-3) with a
// 1-deep pending load register; bcd updates only on a completed conversion.
module bin2bcd_seq
  import score_display_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  score,
  input  logic        score_valid,
  output logic        busy,
  output logic [11:0] bcd
);

  conv_state_t state, state_nx;
  logic [7:0]  sr;
  logic [11:0] acc;
  logic [11:0] acc_adj;
  logic [2:0]  iter;
  logic        pend_valid;
  logic [7:0]  pend_val;
  logic        reload;

  always_comb begin
    acc_adj = acc;
    for (int unsigned i = 0; i < 3; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  // A strobe landing in COMMIT itself is newer than anything pending.
  assign reload = score_valid || pend_valid;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (score_valid) state_nx = SHIFT;
      SHIFT:   if (iter == 3'd7) state_nx = COMMIT;
      COMMIT:  state_nx = reload ? SHIFT : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      sr         <= '0;
      acc        <= '0;
      iter       <= '0;
      pend_valid <= 1'b0;
      pend_val   <= '0;
      bcd        <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (score_valid) begin
            sr   <= score;
            acc  <= '0;
            iter <= '0;
          end
        end
        SHIFT: begin
          {acc, sr} <= {acc_adj[10:0], sr, 1'b0};
          iter      <= iter + 3'd1;
          if (score_valid) begin
            pend_valid <= 1'b1;
            pend_val   <= score;
          end
        end
        COMMIT: begin
          bcd        <= acc;
          pend_valid <= 1'b0;
          if (reload) begin
            sr   <= score_valid ? score : pend_val;
            acc  <= '0;
            iter <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: rtl/score_display.sv
// Score display top: registered BCD conversion feeding a 3-digit multiplexed
// seven-segment display with optional leading-zero blanking.
module score_display
  import score_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 250000,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  score,
  input  logic        score_valid,
  output logic        busy,
  output logic [11:0] bcd,
  output logic [7:0]  seg,
  output logic [2:0]  an
);

  localparam logic [23:0] DIV_LAST = 24'(REFRESH_DIV - 1);

  logic [23:0] cnt;
  logic [1:0]  digit_idx;
  logic [3:0]  nib;
  logic        blank;
  logic [7:0]  seg_nx;
  logic [2:0]  an_nx;

  bin2bcd_seq u_conv (
    .clk         (clk),
    .rst         (rst),
    .score       (score),
    .score_valid (score_valid),
    .busy        (busy),
    .bcd         (bcd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      digit_idx <= '0;
    end else if (cnt == DIV_LAST) begin
      cnt       <= '0;
      digit_idx <= (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
    end else begin
      cnt <= cnt + 24'd1;
    end
  end

  always_comb begin
    nib   = bcd[3:0];
    blank = 1'b0;
    an_nx = AN_OFF;
    case (digit_idx)
      2'd0: begin
        nib   = bcd[3:0];
        an_nx = 3'b110;
      end
      2'd1: begin
        nib   = bcd[7:4];
        blank = BLANK_LZ && (bcd[11:4] == 8'h00);
        an_nx = 3'b101;
      end
      2'd2: begin
        nib   = bcd[11:8];
        blank = BLANK_LZ && (bcd[11:8] == 4'h0);
        an_nx = 3'b011;
      end
      default: ;
    endcase
    seg_nx = blank ? SEG_BLANK : {1'b1, seg7_encode(nib)};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg <= SEG_BLANK;
      an  <= AN_OFF;
    end else begin
      seg <= seg_nx;
      an  <= an_nx;
    end
  end

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display: vector table, directed corner
// sequences, random loads/bursts and an exhaustive 0..255 sweep.
module tb_score_display;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  score = '0;
  logic        score_valid = 1'b0;
  logic        busy, busy_nb;
  logic [11:0] bcd, bcd_nb;
  logic [7:0]  seg, seg_nb;
  logic [2:0]  an, an_nb;

  int errors = 0;
  int checks = 0;
  int edges  = 0;

  always #5 clk = ~clk;

  score_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .score(score), .score_valid(score_valid),
    .busy(busy), .bcd(bcd), .seg(seg), .an(an)
  );

  score_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .score(score), .score_valid(score_valid),
    .busy(busy_nb), .bcd(bcd_nb), .seg(seg_nb), .an(an_nb)
  );

  // Rising edges seen since reset release; drives the display timing model.
  always @(posedge clk or negedge rst) begin
    if (!rst) edges <= 0;
    else      edges <= edges + 1;
  end

  logic [6:0] seg_tab [10];

  typedef struct {
    logic [7:0]  s;
    logic [11:0] exp_bcd;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] exp_seg(input int v, input int digit, input bit blank_lz);
    int d;
    bit blank;
    d = (digit == 0) ? v % 10 : (digit == 1) ? (v / 10) % 10 : v / 100;
    blank = blank_lz && ((digit == 2 && v < 100) || (digit == 1 && v < 10));
    return blank ? 8'hFF : {1'b1, seg_tab[d]};
  endfunction

  task automatic check_display(input int v, input int ncyc);
    int digit;
    logic [2:0] exp_an;
    for (int i = 0; i < ncyc; i++) begin
      digit  = ((edges - 1) / 4) % 3;
      exp_an = ~(3'b001 << digit);
      chk("seg", 32'(seg), 32'(exp_seg(v, digit, 1'b1)));
      chk("an", 32'(an), 32'(exp_an));
      chk("seg_nb", 32'(seg_nb), 32'(exp_seg(v, digit, 1'b0)));
      chk("an_nb", 32'(an_nb), 32'(exp_an));
      @(negedge clk);
    end
  endtask

  task automatic strobe(input logic [7:0] v);
    @(negedge clk);
    score = v;
    score_valid = 1'b1;
    @(negedge clk);
    score_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int a, b, last, nextra, seen42;
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;
    vecs[0] = '{8'd0,   12'h000}; vecs[1] = '{8'd7,   12'h007};
    vecs[2] = '{8'd9,   12'h009}; vecs[3] = '{8'd10,  12'h010};
    vecs[4] = '{8'd99,  12'h099}; vecs[5] = '{8'd100, 12'h100};
    vecs[6] = '{8'd128, 12'h128}; vecs[7] = '{8'd199, 12'h199};
    vecs[8] = '{8'd200, 12'h200}; vecs[9] = '{8'd255, 12'h255};

    // Reset values and first refresh cycles.
    repeat (3) @(negedge clk);
    chk("rst_seg", 32'(seg), 32'hFF);
    chk("rst_an", 32'(an), 32'b111);
    chk("rst_bcd", 32'(bcd), 32'h000);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("first_an", 32'(an), 32'b110);
    chk("first_seg", 32'(seg), 32'hC0);
    check_display(0, 12);

    // Full scale with exact latency.
    strobe(8'd255);
    for (int i = 0; i < 9; i++) begin
      chk("lat_busy", 32'(busy), 32'd1);
      chk("lat_bcd_old", 32'(bcd), 32'h000);
      @(negedge clk);
    end
    chk("lat_busy_done", 32'(busy), 32'd0);
    chk("lat_bcd", 32'(bcd), 32'h255);
    @(negedge clk);
    check_display(255, 12);

    // Blanking case.
    strobe(8'd7);
    wait_idle();
    chk("blank_bcd", 32'(bcd), 32'h007);
    @(negedge clk);
    check_display(7, 12);

    // Table of corner values.
    for (int i = 0; i < 10; i++) begin
      strobe(vecs[i].s);
      wait_idle();
      chk("vec_bcd", 32'(bcd), 32'(vecs[i].exp_bcd));
      chk("vec_bcd_nb", 32'(bcd_nb), 32'(vecs[i].exp_bcd));
    end

    // Back-to-back loads: 100 at N, 42 at N+3, 199 at N+5.
    seen42 = 0;
    @(negedge clk);
    for (int c = 0; c < 24; c++) begin
      score_valid = (c == 0 || c == 3 || c == 5);
      score = (c == 0) ? 8'd100 : (c == 3) ? 8'd42 : 8'd199;
      @(negedge clk);
      score_valid = 1'b0;
      if (bcd == 12'h042) seen42++;
      if (c == 9)  chk("b2b_first", 32'(bcd), 32'h100);
      if (c == 19) chk("b2b_second", 32'(bcd), 32'h199);
    end
    chk("b2b_no42", 32'(seen42), 32'd0);

    // Strobe landing in COMMIT restarts SHIFT immediately.
    strobe(8'd55);
    repeat (8) @(negedge clk);
    score = 8'd201;
    score_valid = 1'b1;
    @(negedge clk);
    score_valid = 1'b0;
    chk("commit_bcd", 32'(bcd), 32'h055);
    chk("commit_busy", 32'(busy), 32'd1);
    wait_idle();
    chk("commit_reload", 32'(bcd), 32'h201);

    // Reset mid-conversion, with a pending load queued.
    strobe(8'd128);
    score = 8'd77;
    score_valid = 1'b1;
    @(negedge clk);
    score_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_bcd", 32'(bcd), 32'h000);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_seg", 32'(seg), 32'hFF);
    chk("mid_rst_an", 32'(an), 32'b111);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_bcd", 32'(bcd), 32'h000);
    chk("post_rst_busy", 32'(busy), 32'd0);
    check_display(0, 6);

    // Random isolated loads with display check.
    for (int i = 0; i < 20; i++) begin
      a = int'($urandom_range(255));
      strobe(8'(a));
      wait_idle();
      chk("rnd_bcd", 32'(bcd), 32'(to_bcd(a)));
      @(negedge clk);
      check_display(a, 3);
      repeat ($urandom_range(3)) @(negedge clk);
    end

    // Random bursts: first value commits, then the latest extra one.
    for (int i = 0; i < 15; i++) begin
      a = int'($urandom_range(255));
      last = -1;
      nextra = 0;
      strobe(8'(a));
      for (int c = 0; c < 8; c++) begin
        if ($urandom_range(2) == 0) begin
          b = int'($urandom_range(255));
          score = 8'(b);
          score_valid = 1'b1;
          last = b;
          nextra++;
        end
        @(negedge clk);
        score_valid = 1'b0;
      end
      @(negedge clk);
      chk("burst_first", 32'(bcd), 32'(to_bcd(a)));
      wait_idle();
      chk("burst_final", 32'(bcd), 32'(to_bcd(nextra > 0 ? last : a)));
    end

    // Exhaustive sweep.
    for (int v = 0; v < 256; v++) begin
      strobe(8'(v));
      wait_idle();
      chk("sweep_bcd", 32'(bcd), 32'(to_bcd(v)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
